// File: rtl/gen_fifo_defines_pkg.sv
// Shared definitions for the generator FIFO slice.
// Provides the sample width / reset value defaults and the sample reader's
// FSM state type and default widths. No ports.

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef RESET_VALUE
`define RESET_VALUE 0
`endif
`ifndef RDR_DIV_WIDTH
`define RDR_DIV_WIDTH 16
`endif
`ifndef RDR_UFLOW_CNT_WIDTH
`define RDR_UFLOW_CNT_WIDTH 8
`endif

package gen_fifo_defines_pkg;

    localparam int unsigned GEN_DATA_WIDTH      = `DATA_WIDTH;
    localparam int          GEN_RESET_VALUE     = `RESET_VALUE;
    localparam int unsigned RDR_DIV_WIDTH       = `RDR_DIV_WIDTH;
    localparam int unsigned RDR_UFLOW_CNT_WIDTH = `RDR_UFLOW_CNT_WIDTH;

    typedef enum logic [1:0] {
        RDR_IDLE,
        RDR_WAIT,
        RDR_CAPTURE,
        RDR_OUT
    } rdr_state_t;

endpackage

// File: rtl/gen_fifo_rate_tick.sv
// Programmable rate divider: one tick every div+1 cycles while enabled.
// Ports: clk, rst (async active-low), en (count enable, clears when low),
// div (live divisor), tick (combinational, high when count == div).

module gen_fifo_rate_tick
    import gen_fifo_defines_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = RDR_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gen_fifo_sample_reader_sva.sv
// Property checker for gen_fifo_sample_reader, attached via bind.
// Ports: observes clk, rst, empty_i, rd_en_o, valid_o, ready_i, data_o,
// underflow_o and uflow_cnt_o of the reader; drives nothing.

module gen_fifo_sample_reader_sva
    import gen_fifo_defines_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = GEN_DATA_WIDTH,
    parameter int unsigned UFLOW_CNT_WIDTH = RDR_UFLOW_CNT_WIDTH
) (
    input logic                         clk,
    input logic                         rst,
    input logic                         empty_i,
    input logic                         rd_en_o,
    input logic                         valid_o,
    input logic                         ready_i,
    input logic signed [DATA_WIDTH-1:0] data_o,
    input logic                         underflow_o,
    input logic [UFLOW_CNT_WIDTH-1:0]   uflow_cnt_o
);

    // Never pop an empty FIFO.
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst)
        rd_en_o |-> !empty_i);

    // Output must hold while the sink stalls.
    a_stable_under_bp: assert property (@(posedge clk) disable iff (!rst)
        (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));

    // Counter sticks at all-ones once saturated.
    a_uflow_saturates: assert property (@(posedge clk) disable iff (!rst)
        (uflow_cnt_o == '1) |=> (uflow_cnt_o == '1));

    // Counter only moves together with an underflow pulse.
    a_uflow_moves_on_pulse: assert property (@(posedge clk) disable iff (!rst)
        !underflow_o |-> $stable(uflow_cnt_o));

endmodule

bind gen_fifo_sample_reader gen_fifo_sample_reader_sva #(
    .DATA_WIDTH      (DATA_WIDTH),
    .UFLOW_CNT_WIDTH (UFLOW_CNT_WIDTH)
) u_sva (
    .clk         (clk),
    .rst         (rst),
    .empty_i     (empty_i),
    .rd_en_o     (rd_en_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .underflow_o (underflow_o),
    .uflow_cnt_o (uflow_cnt_o)
);

// File: rtl/gen_fifo_sample_reader.sv
// Read-side consumer of the generator FIFO. Pops one sample per rate tick and
// presents it on a valid/ready interface; repeats the last sample on underflow.
// Ports: clk, rst (async active-low), en_i, div_i (tick every div_i+1 cycles),
// empty_i / rd_en_o / data_i (FIFO read port, data one cycle after pop),
// data_o / valid_o / ready_i (sink), underflow_o (pulse), uflow_cnt_o
// (saturating), missed_o (sticky: tick dropped outside WAIT, cleared in IDLE).

module gen_fifo_sample_reader
    import gen_fifo_defines_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = GEN_DATA_WIDTH,
    parameter int unsigned DIV_WIDTH       = RDR_DIV_WIDTH,
    parameter int unsigned UFLOW_CNT_WIDTH = RDR_UFLOW_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic [DIV_WIDTH-1:0]         div_i,
    input  logic                         empty_i,
    output logic                         rd_en_o,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         underflow_o,
    output logic [UFLOW_CNT_WIDTH-1:0]   uflow_cnt_o,
    output logic                         missed_o
);

    localparam logic signed [DATA_WIDTH-1:0] RST_DATA = DATA_WIDTH'(GEN_RESET_VALUE);

    rdr_state_t                   state_q, state_d;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic [UFLOW_CNT_WIDTH-1:0]   uflow_cnt_q, uflow_cnt_d;
    logic                         underflow_q, underflow_d;
    logic                         missed_q, missed_d;
    logic                         tick;

    gen_fifo_rate_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_rate_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en_i),
        .div  (div_i),
        .tick (tick)
    );

    assign rd_en_o = (state_q == RDR_WAIT) && tick && !empty_i && en_i;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        uflow_cnt_d = uflow_cnt_q;
        underflow_d = 1'b0;
        missed_d    = missed_q;
        unique case (state_q)
            RDR_IDLE: begin
                missed_d = 1'b0;
                if (en_i) begin
                    state_d = RDR_WAIT;
                end
            end
            RDR_WAIT: begin
                if (!en_i) begin
                    state_d = RDR_IDLE;
                end else if (tick) begin
                    if (!empty_i) begin
                        state_d = RDR_CAPTURE;
                    end else begin
                        // Underflow: re-present the held sample.
                        state_d     = RDR_OUT;
                        underflow_d = 1'b1;
                        if (uflow_cnt_q != '1) begin
                            uflow_cnt_d = uflow_cnt_q + UFLOW_CNT_WIDTH'(1);
                        end
                    end
                end
            end
            RDR_CAPTURE: begin
                // Capture even if en_i just fell, so a popped sample is never lost.
                data_d  = data_i;
                state_d = RDR_OUT;
                if (tick) begin
                    missed_d = 1'b1;
                end
            end
            RDR_OUT: begin
                if (tick) begin
                    missed_d = 1'b1;
                end
                if (ready_i) begin
                    state_d = en_i ? RDR_WAIT : RDR_IDLE;
                end
            end
            default: state_d = RDR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RDR_IDLE;
            data_q      <= RST_DATA;
            uflow_cnt_q <= '0;
            underflow_q <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            uflow_cnt_q <= uflow_cnt_d;
            underflow_q <= underflow_d;
            missed_q    <= missed_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = (state_q == RDR_OUT);
    assign underflow_o = underflow_q;
    assign uflow_cnt_o = uflow_cnt_q;
    assign missed_o    = missed_q;

endmodule

// File: doc/gen_fifo_sample_reader.md
Name: gen_fifo_sample_reader

Overview:
- Read-side consumer of the generator FIFO: pops the signed samples that funct_generator writes and presents them downstream on a valid/ready interface.
- Paced by a programmable rate divider, so the output stream runs at a fixed sample rate independent of the write side.
- On underflow, repeats the last sample and reports it; flags rate ticks missed because the sink stalled.
- Sits between the FIFO read port and the DAC/sink.

Parameters:
- DATA_WIDTH, `DATA_WIDTH, sample width; must match the FIFO data width.
- DIV_WIDTH, 16, width of the rate divider value.
- UFLOW_CNT_WIDTH, 8, width of the saturating underflow counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en_i  in  1  reader enable.
- div_i  in  DIV_WIDTH  rate divisor; one tick every div_i+1 cycles.
- empty_i  in  1  FIFO empty flag.
- rd_en_o  out  1  FIFO pop strobe.
- data_i  in  signed DATA_WIDTH  FIFO read data; valid one cycle after rd_en_o.
- data_o  out  signed DATA_WIDTH  sample to sink.
- valid_o  out  1  data_o valid.
- ready_i  in  1  sink accepts data_o.
- underflow_o  out  1  one-cycle pulse per underflow tick.
- uflow_cnt_o  out  UFLOW_CNT_WIDTH  saturating underflow count.
- missed_o  out  1  sticky: a tick arrived while not in WAIT.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, divider count 0, data_o=`RESET_VALUE, valid_o=0, underflow_o=0, uflow_cnt_o=0, missed_o=0.
- Divider:
  - Counts only while en_i=1 and clears to 0 while en_i=0.
  - tick=1 when count==div_i; count then reloads to 0.
  - div_i=0 gives a tick every cycle; div_i is compared live.
- rd_en_o is combinational: (state==WAIT) & tick & !empty_i & en_i. It is never high while empty_i=1 or outside WAIT.
- FSM states: IDLE, WAIT, CAPTURE, OUT.
  - IDLE: goes to WAIT when en_i=1.
  - WAIT, en_i=0: goes to IDLE.
  - WAIT, tick & !empty_i: pop and go to CAPTURE.
  - WAIT, tick & empty_i: underflow_o=1 next cycle, uflow_cnt_o increments (saturates at all-ones), go to OUT with data_o unchanged.
  - CAPTURE: data_o <= data_i, go to OUT.
  - OUT: valid_o=1; when ready_i=1, go to WAIT if en_i=1, else IDLE.
- Latency: tick and pop in cycle t, CAPTURE in t+1, valid_o=1 and data_o=new sample from t+2. Underflow path: valid_o=1 at t+1.
- valid_o is high exactly in OUT. data_o is stable while valid_o=1 and ready_i=0.
- A tick in CAPTURE or OUT sets missed_o; that tick is dropped and no pop occurs.
- en_i falling:
  - In CAPTURE: the popped sample is still captured and presented, so no sample is lost.
  - In OUT: holds until the handshake completes, then goes to IDLE.
  - In IDLE, missed_o clears.
- If underflow and missed coincide, both are reported.

Decomposition:
- gen_fifo_defines_pkg gains:
  - rdr_state_t enum (IDLE, WAIT, CAPTURE, OUT).
  - `RDR_DIV_WIDTH and `RDR_UFLOW_CNT_WIDTH defaults.
  - Reuses `DATA_WIDTH and `RESET_VALUE.
- Sub-module gen_fifo_rate_tick holds the divider counter and tick generation (en, div -> tick).
- The FSM, output register and counters stay in the top module.
- A formal bind module, in the same style as the generator checker, checks:
  - rd_en_o never high while empty_i=1.
  - valid_o/data_o stable under backpressure.
  - Saturation of uflow_cnt_o.

Test Plan:
- Reset, then en_i=1, div_i=3, FIFO holding 10,20,30, ready_i=1: rd_en_o pulses every 4 cycles; data_o = 10,20,30 with valid_o at tick+2; no underflow.
- div_i=0, FIFO empty, ready_i=1: underflow_o every 2 cycles; data_o repeats last sample (or `RESET_VALUE after reset); uflow_cnt_o saturates at 255 after 255 underflows and stays.
- div_i=1, ready_i held 0 for 10 cycles after the first valid_o: data_o stable; missed_o=1; no further pops until the handshake completes.
- en_i dropped in the CAPTURE cycle with a sample of -5: data_o=-5 with valid_o=1 still presented; after ready_i, state IDLE; en_i low clears missed_o.
- rst asserted mid-OUT with valid_o=1: valid_o=0 and data_o=`RESET_VALUE immediately, without waiting for a clock edge; rd_en_o=0.
- Randomised run with en_i toggling and empty_i random: rd_en_o & empty_i is never 1; the popped sample sequence equals the presented non-underflow sequence.
